// File: rtl/lorenz_decryptor.sv
// Lorenz keystream decryptor: XORs cipher pixels with bytes from a key FIFO
// and streams one frame of decrypted pixels per start pulse.
module lorenz_decryptor #(
   parameter int FRAME_PIXELS = 4096,
   parameter int KEY_DEPTH    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [7:0]                   s_axis_key_tdata,
   input  logic                         s_axis_key_tvalid,
   output logic                         s_axis_key_tready,
   input  logic [7:0]                   s_axis_cipher_tdata,
   input  logic                         s_axis_cipher_tvalid,
   output logic                         s_axis_cipher_tready,
   output logic [7:0]                   m_axis_pixel_tdata,
   output logic                         m_axis_pixel_tvalid,
   input  logic                         m_axis_pixel_tready,
   output logic                         m_axis_pixel_tlast,
   output logic                         done,
   output logic [$clog2(KEY_DEPTH):0]   key_level
);

   localparam int AW = $clog2(KEY_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(FRAME_PIXELS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t         state, state_nx;
   logic [7:0]     mem [KEY_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level;
   logic [CW-1:0]  count;
   logic           push, pop, final_px, out_hs;

   assign s_axis_key_tready    = (level != LW'(KEY_DEPTH));
   assign push                 = s_axis_key_tvalid && s_axis_key_tready;
   assign s_axis_cipher_tready = (state == RUN) && (level != '0) &&
                                 (!m_axis_pixel_tvalid || m_axis_pixel_tready);
   assign pop                  = s_axis_cipher_tvalid && s_axis_cipher_tready;
   assign final_px             = (count == CW'(FRAME_PIXELS - 1));
   assign out_hs               = m_axis_pixel_tvalid && m_axis_pixel_tready;
   assign key_level            = level;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_axis_key_tdata;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (!push && pop) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_pixel_tdata  <= '0;
         m_axis_pixel_tvalid <= 1'b0;
         m_axis_pixel_tlast  <= 1'b0;
      end else if (pop) begin
         m_axis_pixel_tdata  <= s_axis_cipher_tdata ^ mem[rd_ptr];
         m_axis_pixel_tvalid <= 1'b1;
         m_axis_pixel_tlast  <= final_px;
      end else if (out_hs) begin
         m_axis_pixel_tvalid <= 1'b0;
         m_axis_pixel_tlast  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (state == IDLE && start) begin
         count <= '0;
      end else if (pop) begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nx = RUN;
         RUN:   if (pop && final_px) state_nx = DRAIN;
         DRAIN: if (out_hs && m_axis_pixel_tlast) state_nx = DONE;
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lorenz_decryptor.sv
// Bench for lorenz_decryptor: frame-level behavioural model checked every
// cycle, plus directed scenarios with literal expected pixels.
module tb_lorenz_decryptor;

   localparam int NPIX = 4;
   localparam int KD   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] k_d = '0;
   logic       k_v = 1'b0;
   logic       k_rdy;
   logic [7:0] c_d = '0;
   logic       c_v = 1'b0;
   logic       c_rdy;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_rdy = 1'b1;
   logic       m_last;
   logic       done;
   logic [2:0] level;

   lorenz_decryptor #(.FRAME_PIXELS(NPIX), .KEY_DEPTH(KD)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_axis_key_tdata(k_d), .s_axis_key_tvalid(k_v),
      .s_axis_key_tready(k_rdy),
      .s_axis_cipher_tdata(c_d), .s_axis_cipher_tvalid(c_v),
      .s_axis_cipher_tready(c_rdy),
      .m_axis_pixel_tdata(m_data), .m_axis_pixel_tvalid(m_valid),
      .m_axis_pixel_tready(m_rdy), .m_axis_pixel_tlast(m_last),
      .done(done), .key_level(level)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit armed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;

   logic [7:0] kq[$];
   logic [7:0] cq[$];
   logic [7:0] outlog[$];
   logic       lastlog[$];
   int         cyclog[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // Stream drivers: pop the source queues on handshake, log output beats.
   always @(posedge clk) begin
      if (!rst) begin
         if (k_v && k_rdy) void'(kq.pop_front());
         if (c_v && c_rdy) void'(cq.pop_front());
         if (m_valid && m_rdy) begin
            outlog.push_back(m_data);
            lastlog.push_back(m_last);
            cyclog.push_back(cyc);
         end
      end
      cyc++;
      #1;
      k_v = (kq.size() != 0);
      k_d = k_v ? kq[0] : 8'h00;
      c_v = (cq.size() != 0);
      c_d = c_v ? cq[0] : 8'h00;
   end

   // Behavioural model: 0 idle, 1 run, 2 drain, 3 done.
   int         mstate = 0;
   int         mcnt = 0;
   logic [7:0] mkeys[$];
   logic       mvalid = 0;
   logic [7:0] mdata = 0;
   logic       mlast = 0;

   always @(posedge clk) begin
      bit acc, hs, hs_last, last_px, cr, kr;
      logic [7:0] kb;
      last_px = 0;
      if (rst) begin
         mstate = 0;
         mcnt   = 0;
         mkeys.delete();
         mvalid = 0;
         mdata  = 0;
         mlast  = 0;
      end else begin
         cr      = (mstate == 1) && (mkeys.size() != 0) && (!mvalid || m_rdy);
         kr      = (mkeys.size() != KD);
         acc     = cr && c_v;
         hs      = mvalid && m_rdy;
         hs_last = hs && mlast;
         if (acc) begin
            kb      = mkeys.pop_front();
            last_px = (mcnt == NPIX - 1);
            mdata   = c_d ^ kb;
            mvalid  = 1;
            mlast   = last_px;
            mcnt++;
         end else if (hs) begin
            mvalid = 0;
         end
         if (k_v && kr) mkeys.push_back(k_d);
         case (mstate)
            0: if (start) begin mstate = 1; mcnt = 0; end
            1: if (acc && last_px) mstate = 2;
            2: if (hs_last) mstate = 3;
            default: mstate = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (armed) begin
         check("key_level", 32'(level), 32'(mkeys.size()));
         check("key_tready", 32'(k_rdy), 32'(mkeys.size() != KD));
         check("cipher_tready", 32'(c_rdy),
               32'((mstate == 1) && (mkeys.size() != 0) && (!mvalid || m_rdy)));
         check("pixel_tvalid", 32'(m_valid), 32'(mvalid));
         check("done", 32'(done), 32'(mstate == 3));
         if (mvalid) begin
            check("pixel_tdata", 32'(m_data), 32'(mdata));
            check("pixel_tlast", 32'(m_last), 32'(mlast));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      outlog.delete();
      lastlog.delete();
      cyclog.delete();
   endtask

   task automatic wait_keys();
      int n = 0;
      while (kq.size() != 0 && n < 20) begin tick(); n++; end
      check("key_drain_timeout", 32'(kq.size()), 32'd0);
      tick();
   endtask

   task automatic wait_out(input int cnt);
      int n = 0;
      while (outlog.size() < cnt && n < 50) begin tick(); n++; end
      check("output_timeout", 32'(outlog.size() >= cnt), 32'd1);
   endtask

   task automatic wait_done();
      int dc = done_cnt;
      int n = 0;
      while (done_cnt == dc && n < 60) begin tick(); n++; end
      check("done_timeout", 32'(done_cnt - dc), 32'd1);
   endtask

   task automatic check_frame(input string nm, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
      logic [7:0] e[4];
      e = '{e0, e1, e2, e3};
      check({nm, "_count"}, 32'(outlog.size()), 32'd4);
      for (int i = 0; i < 4 && i < outlog.size(); i++) begin
         check({nm, "_px"}, 32'(outlog[i]), 32'(e[i]));
         check({nm, "_last"}, 32'(lastlog[i]), 32'(i == 3));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      kq.delete();
      cq.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int dc;
      tick();
      armed = 1;
      tick();
      rst = 1'b0;
      tick();
      check("reset_key_tready", 32'(k_rdy), 32'd1);
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_data", 32'(m_data), 32'd0);
      check("reset_level", 32'(level), 32'd0);

      // Basic frame, full throughput
      clear_logs();
      kq = '{8'h11, 8'h22, 8'h33, 8'h44};
      wait_keys();
      cq = '{8'h10, 8'h20, 8'h30, 8'h40};
      pulse_start();
      wait_done();
      check_frame("basic", 8'h01, 8'h02, 8'h03, 8'h04);
      if (outlog.size() == 4) begin
         check("basic_back_to_back", 32'(cyclog[3] - cyclog[0]), 32'd3);
         check("basic_done_latency", 32'(done_cyc - cyclog[3]), 32'd1);
      end

      // FIFO full, fifth key held until a pop
      clear_logs();
      kq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      repeat (8) tick();
      check("full_level", 32'(level), 32'd4);
      check("full_tready", 32'(k_rdy), 32'd0);
      check("full_pending", 32'(kq.size()), 32'd1);
      cq = '{8'h00, 8'h00, 8'h00, 8'h00};
      pulse_start();
      wait_done();
      check_frame("full", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
      tick();
      check("full_retained", 32'(level), 32'd1);

      // Key starvation
      do_reset();
      clear_logs();
      cq = '{8'hAA};
      pulse_start();
      repeat (3) tick();
      check("starve_tready", 32'(c_rdy), 32'd0);
      check("starve_no_out", 32'(outlog.size()), 32'd0);
      kq = '{8'hFF};
      wait_out(1);
      kq = '{8'h01, 8'h02, 8'h03};
      cq = '{8'h00, 8'h00, 8'h00};
      wait_done();
      check_frame("starve", 8'h55, 8'h01, 8'h02, 8'h03);

      // Downstream backpressure mid-frame
      clear_logs();
      kq = '{8'h01, 8'h02, 8'h03, 8'h04};
      wait_keys();
      cq = '{8'hF0, 8'hE0, 8'hD0, 8'hC0};
      pulse_start();
      wait_out(1);
      m_rdy = 1'b0;
      repeat (3) tick();
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_cipher_tready", 32'(c_rdy), 32'd0);
      m_rdy = 1'b1;
      wait_done();
      check_frame("stall", 8'hF1, 8'hE2, 8'hD3, 8'hC4);

      // Reset in the middle of a frame
      clear_logs();
      kq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
      wait_keys();
      cq = '{8'h01, 8'h02, 8'h03, 8'h04};
      pulse_start();
      wait_out(2);
      dc = done_cnt;
      do_reset();
      check("abort_valid", 32'(m_valid), 32'd0);
      check("abort_data", 32'(m_data), 32'd0);
      check("abort_level", 32'(level), 32'd0);
      check("abort_cipher_tready", 32'(c_rdy), 32'd0);
      repeat (4) tick();
      check("abort_no_done", 32'(done_cnt - dc), 32'd0);
      clear_logs();
      kq = '{8'h10, 8'h20, 8'h30, 8'h40};
      wait_keys();
      cq = '{8'h01, 8'h02, 8'h03, 8'h04};
      pulse_start();
      wait_done();
      check_frame("after_abort", 8'h11, 8'h22, 8'h33, 8'h44);

      // start during RUN is ignored
      clear_logs();
      kq = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
      wait_keys();
      pulse_start();
      cq = '{8'hF0};
      wait_out(1);
      pulse_start();
      cq = '{8'hF1, 8'hF2, 8'hF3};
      wait_done();
      check_frame("restart", 8'hFF, 8'hFE, 8'hFD, 8'hFC);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
